rim_path_checker: RTL and testbench
===================================

Name: rim_path_checker

Overview:
- Downstream stage of the maze solver. Consumes its coordinate stream: one (row,col) per cycle while the solver's valid is high, 2N-1 beats from (0,0) to (N-1,N-1).
- Checks the path for legality and packs it into a move vector, with a turn count and error flags.
- Presents the result on a valid/ready handshake to the scoring/display logic.

Parameters:
- N, 8, maze side length; path length is 2N-1 beats, 2N-2 moves.
- CW, 3, coordinate width; must satisfy 2^CW >= N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  coordinate beat valid; a burst is a contiguous run of high cycles.
- in_row  input  CW  path row of the beat.
- in_col  input  CW  path column of the beat.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result when high together with out_valid.
- out_moves  output  2N-2  bit k = move k (1 = down/row+1, 0 = right/col+1); bit 0 is the first move.
- out_turns  output  $clog2(2N-2)  number of k>0 with move[k] != move[k-1].
- out_err  output  3  [0] first beat != (0,0); [1] some step not a unit down or unit right; [2] beat count != 2N-1 or last beat != (N-1,N-1).
- busy  output  1  high in COLLECT and HOLD.

Behaviour:
- Reset: out_valid=0, out_moves=0, out_turns=0, out_err=0, busy=0; FSM goes to IDLE; internal count, prev coordinate and flags are cleared. Reset mid-burst or mid-hold discards everything; no partial result is ever presented.
- States and transitions:
  - IDLE: on an edge with in_valid=1, capture the beat as start, check err[0], set count=1, prev=beat, and go to COLLECT.
  - COLLECT, in_valid=1:
    - Legal step: exactly one of (row==prev_row+1, col==prev_col) and (row==prev_row, col==prev_col+1).
    - The compare uses CW+1-bit sums, so N-1 -> 0 wrap is illegal.
    - Any other step sets sticky err[1].
    - While count <= 2N-2, write the move bit into index count-1 and update turns.
    - Beats beyond 2N-1 are not stored; they only raise err[2].
    - The count saturates at 2N; prev and last update on every beat.
    - An illegal step records its move bit as 1 if the row changed, else 0.
  - COLLECT, in_valid=0: the first low cycle ends the burst.
    - On that edge, evaluate err[2] from count and last.
    - Register out_moves, out_turns and out_err; unfilled move bits are 0.
    - Set out_valid=1 and go to HOLD.
    - Latency: out_valid is high the cycle after the last beat's cycle + 1, i.e. one edge after in_valid falls.
  - HOLD: outputs stable while out_valid=1 and out_ready=0. in_valid beats are ignored (dropped) while out_ready=0.
  - Acceptance: on an edge with out_valid && out_ready, out_valid becomes 0. If in_valid=1 on the same edge, that beat starts a new burst exactly as in IDLE and the FSM goes to COLLECT; otherwise it goes to IDLE.
- A single-beat burst (0,0) gives moves=0, turns=0, err=3'b100.
- out_turns is only counted between stored moves; max 2N-3.
- busy is combinational from state.

Test Plan:
- Path right x7 then down x7: (0,0),(0,1)..(0,7),(1,7)..(7,7), out_ready=1 -> out_valid one edge after in_valid falls; moves=14'h3F80, turns=1, err=0; out_valid drops next edge.
- Staircase down, right, down, ... to (7,7) -> moves=14'h1555, turns=13, err=0.
- Short burst (0,0),(1,0),(1,1) -> moves=14'h0001, turns=1, err=3'b100.
- Burst (0,1),(1,1),(2,2),... of 15 beats ending (7,7) -> err[0]=1, err[1]=1; wrap step (0,7)->(0,0) in another burst -> err[1]=1.
- Back-pressure: out_ready=0 for 5 cycles with a burst injected meanwhile -> outputs unchanged, burst dropped. Then assert out_ready with in_valid=1 at (0,0) on the same edge -> first result accepted, new burst is processed and its result is correct.
- rst_n pulsed low at beat 6 of a valid path -> out_valid stays 0, busy=0; a following full valid burst yields a correct result with err=0.

Source files
------------

// File: rtl/rim_path_checker.sv
// Maze path checker: collects a (row,col) burst from the solver, validates each step,
// packs the moves into a bit vector with a turn count, and presents it on valid/ready.
module rim_path_checker #(
  parameter int N  = 8,
  parameter int CW = 3,
  localparam int MW = 2*N-2,
  localparam int TW = $clog2(2*N-2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_row,
  input  logic [CW-1:0] in_col,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_moves,
  output logic [TW-1:0] out_turns,
  output logic [2:0]    out_err,
  output logic          busy
);

  localparam int KW = $clog2(2*N+1);
  localparam logic [KW-1:0] CNT_SAT   = KW'(2*N);
  localparam logic [KW-1:0] CNT_FULL  = KW'(2*N-1);
  localparam logic [KW-1:0] CNT_STORE = KW'(MW);
  localparam logic [KW-1:0] CNT_ONE   = KW'(1);
  localparam logic [CW-1:0] LAST      = CW'(N-1);
  localparam logic [CW:0]   ONE_W     = (CW+1)'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   count;
  logic [CW-1:0]   prev_row, prev_col;   // also serves as the last beat at burst end
  logic [MW-1:0]   moves;
  logic [TW-1:0]   turns;
  logic            prev_move;
  logic            err0, err1;

  logic            start_beat, collect_beat, burst_end;
  logic            step_down, step_right, step_ok, move_bit, store, turn_inc, err2_end;
  logic [KW-1:0]   idx;
  logic [MW-1:0]   move_mask;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = COLLECT;
      COLLECT: if (!in_valid) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = in_valid ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A beat accepted on the same edge as the result starts the next burst directly.
  assign start_beat   = in_valid && ((state == IDLE) || (state == HOLD && out_ready));
  assign collect_beat = in_valid && (state == COLLECT);
  assign burst_end    = !in_valid && (state == COLLECT);

  // Widened sums so that N-1 -> 0 never looks like a unit step.
  assign step_down  = ({1'b0, in_row} == {1'b0, prev_row} + ONE_W) && (in_col == prev_col);
  assign step_right = (in_row == prev_row) && ({1'b0, in_col} == {1'b0, prev_col} + ONE_W);
  assign step_ok    = step_down ^ step_right;
  assign move_bit   = step_ok ? step_down : (in_row != prev_row);
  assign store      = (count <= CNT_STORE);
  assign turn_inc   = store && (count > CNT_ONE) && (move_bit != prev_move);
  assign idx        = count - CNT_ONE;
  assign move_mask  = {{(MW-1){1'b0}}, move_bit} << idx;
  assign err2_end   = (count != CNT_FULL) || (prev_row != LAST) || (prev_col != LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      prev_row  <= '0;
      prev_col  <= '0;
      moves     <= '0;
      turns     <= '0;
      prev_move <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      out_valid <= 1'b0;
      out_moves <= '0;
      out_turns <= '0;
      out_err   <= '0;
    end else begin
      if (start_beat) begin
        count     <= CNT_ONE;
        prev_row  <= in_row;
        prev_col  <= in_col;
        moves     <= '0;
        turns     <= '0;
        prev_move <= 1'b0;
        err0      <= (in_row != '0) || (in_col != '0);
        err1      <= 1'b0;
      end else if (collect_beat) begin
        prev_row <= in_row;
        prev_col <= in_col;
        if (count != CNT_SAT) count <= count + CNT_ONE;
        if (!step_ok)         err1  <= 1'b1;
        if (store) begin
          moves     <= moves | move_mask;
          prev_move <= move_bit;
          if (turn_inc) turns <= turns + TW'(1);
        end
      end

      if (burst_end) begin
        out_moves <= moves;
        out_turns <= turns;
        out_err   <= {err2_end, err1, err0};
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rim_path_checker.sv
// Directed bench for rim_path_checker (N=8): legal paths, malformed bursts,
// back-pressure with same-edge restart, and mid-burst reset.
module tb_rim_path_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_row, in_col;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_moves;
  logic [3:0]  out_turns;
  logic [2:0]  out_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] q[$];

  rim_path_checker #(.N(8), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_moves (out_moves),
    .out_turns (out_turns),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input int c);
    q.push_back({r[2:0], c[2:0]});
  endtask

  task automatic build_right_down();
    q.delete();
    push(0, 0);
    for (int c = 1; c < 8; c++) push(0, c);
    for (int r = 1; r < 8; r++) push(r, 7);
  endtask

  task automatic build_stair();
    q.delete();
    push(0, 0);
    for (int i = 1; i < 8; i++) begin
      push(i, i-1);
      push(i, i);
    end
  endtask

  // Called just after a falling edge; leaves in_valid low after the last beat.
  task automatic send_from(input int start);
    for (int i = start; i < q.size(); i++) begin
      in_valid = 1'b1;
      {in_row, in_col} = q[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic check_result(input string tag, input logic [13:0] m, input logic [3:0] t,
                              input logic [2:0] e);
    check({tag, "_moves"}, out_moves, m);
    check({tag, "_turns"}, out_turns, t);
    check({tag, "_err"},   out_err,   e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_col = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy,      0);
    check_result("rst", 14'h0000, 4'd0, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Right x7 then down x7; result exactly one edge after in_valid falls.
    build_right_down();
    send_from(0);
    @(negedge clk);
    check("t1_latency", out_valid, 1);
    check("t1_busy", busy, 1);
    check_result("t1", 14'h3F80, 4'd1, 3'b000);
    @(negedge clk);
    check("t1_drop", out_valid, 0);
    check("t1_idle", busy, 0);

    // Staircase down/right alternating.
    build_stair();
    send_from(0);
    wait_valid("t2");
    check_result("t2", 14'h1555, 4'd13, 3'b000);
    @(negedge clk);

    // Short burst.
    q.delete();
    push(0, 0); push(1, 0); push(1, 1);
    send_from(0);
    wait_valid("t3");
    check_result("t3", 14'h0001, 4'd1, 3'b100);
    @(negedge clk);

    // Bad start, diagonal step and two stays, but 15 beats ending at (7,7).
    q.delete();
    push(0, 1); push(1, 1); push(2, 2); push(2, 2); push(3, 2); push(3, 3);
    push(4, 3); push(4, 4); push(5, 4); push(5, 5); push(6, 5); push(6, 6);
    push(7, 6); push(7, 7); push(7, 7);
    send_from(0);
    wait_valid("t4");
    check_result("t4", 14'h0AAB, 4'd11, 3'b011);
    @(negedge clk);

    // Column wrap 7 -> 0 is not a right step.
    q.delete();
    for (int c = 0; c < 8; c++) push(0, c);
    push(0, 0);
    send_from(0);
    wait_valid("t5");
    check_result("t5", 14'h0000, 4'd0, 3'b110);
    @(negedge clk);

    // Back-pressure: hold the result, drop an injected burst, then restart on accept edge.
    out_ready = 1'b0;
    build_right_down();
    send_from(0);
    wait_valid("t6a");
    check_result("t6a", 14'h3F80, 4'd1, 3'b000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_row = i[2:0];
      in_col = 3'd0;
      @(negedge clk);
      check("t6_hold_valid", out_valid, 1);
      check("t6_hold_moves", out_moves, 14'h3F80);
    end
    check_result("t6_held", 14'h3F80, 4'd1, 3'b000);
    build_stair();
    in_valid = 1'b1;
    {in_row, in_col} = q[0];
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_accept", out_valid, 0);
    check("t6_restart_busy", busy, 1);
    send_from(1);
    wait_valid("t6b");
    check_result("t6b", 14'h1555, 4'd13, 3'b000);
    @(negedge clk);

    // Reset after six beats discards the partial burst.
    build_right_down();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      {in_row, in_col} = q[i];
      @(negedge clk);
    end
    check("t7_busy_pre", busy, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t7_rst_busy",  busy,      0);
    check("t7_rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_post_valid", out_valid, 0);
    check("t7_post_busy",  busy,      0);
    build_stair();
    send_from(0);
    wait_valid("t7");
    check_result("t7", 14'h1555, 4'd13, 3'b000);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
